// File: rtl/mvau_inp_buf_ctrl.sv
// MVAU input buffer sequencer: streams one vector into the buffer on the
// first neuron fold and replays it from the buffer for the remaining folds.
module mvau_inp_buf_ctrl #(
    parameter int SF       = 4,
    parameter int NF       = 3,
    parameter int BUF_ADDR = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_v,
    output logic                in_rdy,
    input  logic                out_rdy,
    output logic                out_v,
    output logic                wr_en,
    output logic                rd_en,
    output logic [BUF_ADDR-1:0] addr,
    output logic                sf_first,
    output logic                sf_last,
    output logic                vec_done
);

    localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
    localparam int NFW = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [SFW-1:0] SF_MAX = SFW'(SF - 1);
    localparam logic [NFW-1:0] NF_MAX = NFW'(NF - 1);

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [SFW-1:0] sf_cnt, sf_cnt_n;
    logic [NFW-1:0] nf_cnt, nf_cnt_n;
    logic           xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= WRITE;
            sf_cnt <= '0;
            nf_cnt <= '0;
        end else begin
            state  <= state_n;
            sf_cnt <= sf_cnt_n;
            nf_cnt <= nf_cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        sf_cnt_n = sf_cnt;
        nf_cnt_n = nf_cnt;
        xfer     = 1'b0;
        in_rdy   = 1'b0;
        out_v    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        addr     = '0;
        sf_first = 1'b0;
        sf_last  = 1'b0;
        vec_done = 1'b0;
        if (!rst) begin
            unique case (state)
                WRITE: begin
                    in_rdy = out_rdy;
                    out_v  = in_v;
                    xfer   = in_v & out_rdy;
                    wr_en  = xfer;
                end
                READ: begin
                    out_v = 1'b1;
                    rd_en = 1'b1;
                    xfer  = out_rdy;
                end
                default: ;
            endcase
            addr     = BUF_ADDR'(sf_cnt);
            sf_first = (sf_cnt == '0) && out_v;
            sf_last  = (sf_cnt == SF_MAX) && out_v;
            // Fold ends on the last synapse word; last fold returns to WRITE.
            if (xfer) begin
                if (sf_cnt != SF_MAX) begin
                    sf_cnt_n = sf_cnt + 1'b1;
                end else begin
                    sf_cnt_n = '0;
                    if (nf_cnt != NF_MAX) begin
                        nf_cnt_n = nf_cnt + 1'b1;
                        state_n  = READ;
                    end else begin
                        nf_cnt_n = '0;
                        state_n  = WRITE;
                        vec_done = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/mvau_inp_buf_ctrl.md
Name: mvau_inp_buf_ctrl

Overview:
- Sequencer that drives the MVAU stream input buffer's wr_en, rd_en and addr.
- Moves the input-activation stream into the buffer on the first neuron fold (NF pass 0) and passes each word through to compute in the same cycle.
- Replays the stored vector from the buffer for neuron folds 1..NF-1.
- Sits between the upstream activation handshake and the SIMD/PE compute array. Provides fold-boundary strobes for the accumulators.

Parameters:
- SF, 4: synapse folds, MatrixW/SIMD; buffer words per input vector; >=1.
- NF, 3: neuron folds, MatrixH/PE; replays per vector; >=1.
- BUF_ADDR, 16: buffer address width; must satisfy 2^BUF_ADDR >= SF.

Ports:
- clk, input, 1: main clock.
- rst, input, 1: synchronous active-high reset.
- in_v, input, 1: upstream activation word valid.
- in_rdy, output, 1: controller accepts an upstream word this cycle.
- out_rdy, input, 1: compute array can consume a word this cycle.
- out_v, output, 1: buffer output (pass-through or stored) is valid to compute.
- wr_en, output, 1: buffer write enable.
- rd_en, output, 1: buffer read select (1 = stored word, 0 = live input).
- addr, output, BUF_ADDR: buffer address. Equals sf_cnt, zero-extended.
- sf_first, output, 1: qualifies the first word of a fold (sf_cnt==0). Accumulator clear.
- sf_last, output, 1: qualifies the last word of a fold (sf_cnt==SF-1). Accumulator result valid.
- vec_done, output, 1: one-cycle strobe on the final transfer of the final fold.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State: two states, WRITE and READ. Counters:
  - sf_cnt, width max(1, clog2(SF)).
  - nf_cnt, width max(1, clog2(NF)).
- Reset: state=WRITE, sf_cnt=0, nf_cnt=0. While rst=1, in_rdy, out_v, wr_en, rd_en, sf_first, sf_last and vec_done are forced 0, and addr=0.
- Transfer definition, xfer:
  - WRITE: xfer = in_v & out_rdy.
  - READ: xfer = out_rdy.
- WRITE state (nf_cnt=0):
  - in_rdy=out_rdy, out_v=in_v, rd_en=0, wr_en=xfer, addr=sf_cnt.
  - The word is written and passed through in the same cycle, so pass-through latency is 0.
- READ state:
  - in_rdy=0, out_v=1, rd_en=1, wr_en=0, addr=sf_cnt.
  - The buffer read is combinational, so stored data is valid the same cycle.
- sf_first=(sf_cnt==0)&out_v and sf_last=(sf_cnt==SF-1)&out_v. Both are combinational.
- Counter update on xfer:
  - sf_cnt<SF-1: sf_cnt++.
  - Else sf_cnt=0 and the fold ends:
    - nf_cnt<NF-1: nf_cnt++, state=READ.
    - nf_cnt==NF-1: nf_cnt=0, state=WRITE, vec_done=1 that cycle (combinational, qualified by xfer).
- No xfer: all registers hold. out_v may deassert in WRITE; it never drops in READ. Words are never skipped or duplicated.
- NF=1: READ is never entered. Every fold is WRITE; vec_done fires on every sf_last xfer.
- SF=1: addr is constant 0. sf_first and sf_last are both asserted on every word.
- Back-to-back vectors: the WRITE for vector k+1 starts the cycle after vec_done, with no bubble. Overwriting buffer[0] is safe because vector k reads are complete.
- Reset mid-operation:
  - Any state or count returns to WRITE/0 on the next edge.
  - Stale buffer contents are never read before being rewritten.
  - An upstream word presented in the rst cycle is not accepted (in_rdy=0).
- Combinational paths:
  - in_v→out_v, wr_en.
  - out_rdy→in_rdy, wr_en.
  - No combinational loop; in_rdy does not depend on in_v.

Test Plan:
- SF=4, NF=3, in_v and out_rdy held 1, words A0..A3 → cycles 0-3 WRITE with addr 0,1,2,3 and wr_en=1; cycles 4-11 READ with addr 0,1,2,3,0,1,2,3, rd_en=1, in_rdy=0; sf_last at cycles 3, 7, 11; vec_done only at cycle 11; cycle 12 WRITE addr 0.
- Same config, in_v low on cycles 1-2 of WRITE → wr_en=0, out_v=0, addr holds 1; A1 is written at addr 1 once in_v returns; total 4 writes, 8 reads.
- READ state, out_rdy low for 3 cycles at sf_cnt=2 → addr stays 2, out_v=1, no counter advance; resumes at 2 and continues to 3.
- NF=1, SF=2, continuous stream → rd_en never 1; vec_done every 2nd transfer; addr alternates 0,1.
- rst asserted at nf_cnt=1, sf_cnt=2 → next cycle state=WRITE, addr=0, in_rdy=out_rdy; the following vector runs the full 4 writes + 8 reads with correct data.
- SF=1, NF=2 → addr always 0; sf_first=sf_last=1 on each word; sequence W,R repeating; vec_done on every R.
